// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO family.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array: synchronous write, registered read.
module fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count, threshold flags and sticky errors.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH,
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write,
  input  logic                   read,
  input  logic [WIDTH-1:0]       datain,
  output logic [WIDTH-1:0]       dataout,
  output logic                   valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [clog2(DEPTH):0]  count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  if ((WIDTH < 1) || (DEPTH < 2) ||
      ((DEPTH & (DEPTH - 1)) != 0) ||
      (AF_LEVEL < 1) || (AF_LEVEL > DEPTH) ||
      (AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_params
    $error("sync_fifo: illegal parameters");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              full_w, empty_w;
  logic              rd_acc, wr_acc;
  fifo_status_t      st;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);
  assign rd_acc  = read & ~empty_w;
  assign wr_acc  = write & (~full_w | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = rd_acc;
    ovf_d    = ovf_q | (write & ~wr_acc);
    unf_d    = unf_q | (read & empty_w);
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_acc),
    .waddr(wr_ptr_q),
    .wdata(datain),
    .re   (rd_acc),
    .raddr(rd_ptr_q),
    .rdata(dataout)
  );

  // Flags come from registered count only, so no input-to-output path.
  always_comb begin
    st.full         = full_w;
    st.empty        = empty_w;
    st.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    st.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    st.overflow     = ovf_q;
    st.underflow    = unf_q;
  end

  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;
  assign count        = count_q;
  assign valid        = valid_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed vector bench for sync_fifo with default parameters.
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       write;
  logic       read;
  logic [7:0] datain;
  logic [7:0] dataout;
  logic       valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int tests;
  int fails;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    logic [4:0] cnt;
    logic       vld;
    logic [7:0] dout;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vq[$];

  sync_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .write       (write),
    .read        (read),
    .datain      (datain),
    .dataout     (dataout),
    .valid       (valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic w, input logic r,
                              input logic [7:0] d,
                              input logic [4:0] cnt,
                              input logic vld,
                              input logic [7:0] dout,
                              input logic ovf, input logic unf);
    vec_t v;
    v.w = w; v.r = r; v.d = d; v.cnt = cnt;
    v.vld = vld; v.dout = dout; v.ovf = ovf; v.unf = unf;
    vq.push_back(v);
  endfunction

  // Flag expectations for DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.
  task automatic check(input string nm, input logic [4:0] cnt,
                       input logic vld, input logic [7:0] dout,
                       input logic ovf, input logic unf);
    logic [19:0] exp_v;
    logic [19:0] act_v;
    exp_v = {cnt, cnt == 5'd16, cnt == 5'd0, cnt >= 5'd14,
             cnt <= 5'd2, vld, dout, ovf, unf};
    act_v = {count, full, empty, almost_full, almost_empty,
             valid, dataout, overflow, underflow};
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got cnt=%0d f=%b e=%b af=%b ae=%b v=%b d=%h o=%b u=%b, want cnt=%0d v=%b d=%h o=%b u=%b",
               nm, count, full, empty, almost_full, almost_empty,
               valid, dataout, overflow, underflow,
               cnt, vld, dout, ovf, unf);
    end
  endtask

  task automatic run_table(input string tag);
    foreach (vq[i]) begin
      write  = vq[i].w;
      read   = vq[i].r;
      datain = vq[i].d;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", tag, i), vq[i].cnt, vq[i].vld,
            vq[i].dout, vq[i].ovf, vq[i].unf);
    end
    write = 1'b0;
    read  = 1'b0;
    vq.delete();
  endtask

  task automatic do_reset();
    write = 1'b0;
    read  = 1'b0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    write  = 1'b0;
    read   = 1'b0;
    datain = 8'h00;
    rst    = 1'b1;
    #1;
    check("por", 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    do_reset();

    // Non-idle state, then a mid-cycle asynchronous reset
    add(1, 0, 8'h33, 5'd1, 0, 8'h00, 0, 0);
    add(1, 0, 8'h44, 5'd2, 0, 8'h00, 0, 0);
    add(0, 1, 8'h00, 5'd1, 1, 8'h33, 0, 0);
    run_table("pre_rst");
    #3 rst = 1'b1;
    #1;
    check("rst_async", 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_hold[%0d]", i), 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    rst = 1'b0;

    // Fill, overflow, drain, underflow
    for (int i = 0; i < 16; i++)
      add(1, 0, 8'(i + 1), 5'(i + 1), 0, 8'h00, 0, 0);
    add(1, 0, 8'hFF, 5'd16, 0, 8'h00, 1, 0);
    for (int i = 0; i < 16; i++)
      add(0, 1, 8'h00, 5'(15 - i), 1, 8'(i + 1), 1, 0);
    add(0, 1, 8'h00, 5'd0, 0, 8'h10, 1, 1);
    add(0, 0, 8'h00, 5'd0, 0, 8'h10, 1, 1);
    run_table("fill_drain");
    do_reset();

    // Full with simultaneous write+read, pointers wrap
    for (int i = 0; i < 16; i++)
      add(1, 0, 8'(i + 1), 5'(i + 1), 0, 8'h00, 0, 0);
    for (int k = 0; k < 20; k++)
      add(1, 1, 8'(8'h20 + k), 5'd16, 1,
          (k < 16) ? 8'(k + 1) : 8'(8'h20 + k - 16), 0, 0);
    for (int i = 0; i < 16; i++)
      add(0, 1, 8'h00, 5'(15 - i), 1, 8'(8'h24 + i), 0, 0);
    add(0, 0, 8'h00, 5'd0, 0, 8'h33, 0, 0);
    run_table("full_rw");
    do_reset();

    // Empty with simultaneous write+read: no bypass
    add(1, 1, 8'hAA, 5'd1, 0, 8'h00, 0, 1);
    add(0, 1, 8'h00, 5'd0, 1, 8'hAA, 0, 1);
    add(0, 0, 8'h00, 5'd0, 0, 8'hAA, 0, 1);
    run_table("empty_rw");
    do_reset();

    // Reset in the middle of a read stream
    for (int i = 0; i < 5; i++)
      add(1, 0, 8'(8'h11 + i), 5'(i + 1), 0, 8'h00, 0, 0);
    run_table("pre_rd");
    read = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_in_read", 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    read = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_read_hold", 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    add(1, 0, 8'h5A, 5'd1, 0, 8'h00, 0, 0);
    add(0, 1, 8'h00, 5'd0, 1, 8'h5A, 0, 0);
    add(0, 0, 8'h00, 5'd0, 0, 8'h5A, 0, 0);
    run_table("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Parametrised single-clock FIFO, successor to the team's one-entry write/read buffer. Generalised in data width and depth, with real pointer-based storage. Adds full/empty, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Sits between producer and consumer logic in the same clock domain, as the standard buffering block for datapath blocks.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
write  input  1  write request; accepted when !full or read is also accepted
read  input  1  read request; accepted when !empty
datain  input  WIDTH  write data, sampled on accepted write
dataout  output  WIDTH  read data, registered
valid  output  1  dataout updated this cycle (pulse, 1 clk)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All state is updated on the rising clk edge, except the asynchronous clear on rst.
- Reset, asynchronous, any time (including mid-operation):
  - wr_ptr = rd_ptr = 0, count = 0, dataout = 0, valid = 0.
  - overflow = underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0 (AF_LEVEL >= 1).
  - Memory contents are not cleared. Any in-flight read result is lost.
- Pointers: ADDR_W = $clog2(DEPTH) bits each. They wrap naturally from DEPTH-1 to 0. Full and empty are derived from count, not from pointer compare.
- rd_acc = read & !empty.
- wr_acc = write & (!full | rd_acc).
- Write: on wr_acc, mem[wr_ptr] <= datain and wr_ptr++.
- Read: on rd_acc, dataout <= mem[rd_ptr], rd_ptr++, and valid = 1 the next cycle.
  - Latency is 1 clk from the read edge to dataout/valid.
  - dataout holds its value when there is no accepted read.
- Count:
  - +1 on wr_acc & !rd_acc.
  - -1 on rd_acc & !wr_acc.
  - Unchanged when both or neither are accepted.
- Flags full, empty, almost_full, almost_empty and count reflect state after the edge. There is no combinational path from write/read to any output.
- Simultaneous events:
  - Empty, write+read: write accepted; read rejected with underflow = 1. No same-cycle bypass: the data becomes readable on the next cycle.
  - Full, write+read: both accepted. Oldest word is read, new word stored, count stays DEPTH, no overflow.
  - Full, write only: write dropped, memory and pointers unchanged, overflow = 1.
- overflow and underflow are sticky until rst.
- Illegal parameters (DEPTH not a power of two, thresholds out of range) are caught by an elaboration-time check that stops elaboration.

Decomposition:
- Shared package fifo_pkg:
  - function clog2 helper.
  - Default WIDTH/DEPTH constants.
  - Typedef of the status struct {full, empty, almost_full, almost_empty, overflow, underflow} for reuse by future async/multi-channel variants.
- One sub-module: fifo_mem.
  - Simple dual-port register array, WIDTH x DEPTH.
  - Synchronous write port.
  - Registered read port with read-enable.
  - No reset on the array.
- Pointer, count and flag logic stay in sync_fifo.

Test Plan:
- Reset then idle, with rst asserted mid-cycle -> immediately count=0, empty=1, full=0, dataout=0, valid=0; holds for 5 clks.
- Default params: write 16 words 0x01..0x10, then one more write of 0xFF -> full=1 after the 16th; almost_full from count 14; count=16; overflow=1; 0xFF is not stored.
- Read 16 words -> dataout 0x01..0x10 in order, each 1 clk after its read with valid pulse. Then empty=1, almost_empty at count<=2; a 17th read sets underflow=1 and dataout stays 0x10.
- Fill to 16, then 20 cycles of write+read with data 0x20..0x33 -> count stays 16, no overflow. Read-out order is 0x01..0x10 then 0x20..; pointer wrap verified.
- Empty FIFO, write+read same cycle with 0xAA -> underflow=1, count=1. A read next cycle returns 0xAA one clk later.
- Write 5 words, assert rst during a read -> all outputs return to reset values at once. A following write/read of 0x5A returns 0x5A (no stale data).
